// File: rtl/twos_to_signmag.sv
// twos_to_signmag: bit-serial two's-complement to sign-magnitude converter.
// The word is consumed LSB first, one bit per clock. Negative words use
// copy-until-first-one-then-invert to form -din; positive words pass through.
// Latency is fixed at WIDTH shift cycles regardless of the data value.
module twos_to_signmag #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [WIDTH-1:0] mag,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             seen_q, seen_d;

  // Current LSB and the corresponding magnitude bit produced this cycle.
  logic b, obit;

  // Serial datapath bit: once a one has gone by, a negative word's bits invert.
  always_comb begin
    b    = sr_q[0];
    obit = (sign_q && seen_q) ? ~b : b;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    seen_d  = seen_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = din;
          sign_d  = din[WIDTH-1];
          seen_d  = 1'b0;
          cnt_d   = '0;
          mag_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sign_q) seen_d = seen_q | b;
        mag_d = {obit, mag_q[WIDTH-1:1]};
        sr_d  = {1'b0, sr_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      mag_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      seen_q  <= seen_d;
    end
  end

  // Handshake and status decodes; sign/mag are qualified by out_valid only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    sign      = sign_q;
    mag       = mag_q;
  end

endmodule

// File: tb/tb_twos_to_signmag.sv
// Directed and randomized bench for twos_to_signmag. Inputs are driven and
// outputs sampled on the falling edge, away from the active rising edge.
module tb_twos_to_signmag;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic             sign;
  logic [WIDTH-1:0] mag;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  twos_to_signmag #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sign     (sign),
    .mag      (mag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Offer a word at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input string tag, input logic [WIDTH-1:0] w);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      cyc(1);
      n++;
    end
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    din      = w;
    cyc(1);
    in_valid = 1'b0;
    din      = $urandom;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin
      cyc(1);
      n++;
    end
    chk({tag, "_tmo"}, 64'(out_valid), 64'd1);
  endtask

  // Wait for the result, check it, then release it with a one-cycle out_ready.
  task automatic recv(input string tag, input logic exp_s, input logic [WIDTH-1:0] exp_m,
                      input int hold);
    wait_out(tag);
    cyc(hold);
    chk({tag, "_res"}, {31'd0, sign, mag}, {31'd0, exp_s, exp_m});
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk({tag, "_rel"}, {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
  endtask

  task automatic convert(input string tag, input logic [WIDTH-1:0] w,
                         input logic exp_s, input logic [WIDTH-1:0] exp_m);
    send(tag, w);
    recv(tag, exp_s, exp_m, 0);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] w, em;
    logic [WIDTH-1:0] stim [6];
    logic [WIDTH-1:0] exm  [6];
    logic             exs  [6];

    rst = 1'b1; in_valid = 1'b0; din = '0; out_ready = 1'b0;
    #12;
    chk("rst_state", {59'd0, in_ready, out_valid, busy, sign, mag != 0},
        {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    cyc(1);

    // Latency: out_valid must first appear after exactly WIDTH edges past accept.
    send("lat", 32'h0000_0005);
    chk("lat_busy", 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 100) begin
      cyc(1);
      n++;
    end
    chk("lat_edges", 64'(n), 64'(WIDTH));
    recv("lat", 1'b0, 32'h0000_0005, 0);

    // Directed values with hand-computed magnitudes.
    stim = '{32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000,
             32'h7FFF_FFFF, 32'hFFFF_FF00};
    exs  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exm  = '{32'h0000_0005, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000,
             32'h7FFF_FFFF, 32'h0000_0100};
    for (int i = 0; i < 6; i++) convert($sformatf("dir%0d", i), stim[i], exs[i], exm[i]);

    // Backpressure with stray in_valid pulses during SHIFT and DONE.
    send("bp", 32'hFFFF_FFFB);
    in_valid = 1'b1; din = 32'h0000_1111;
    cyc(3);
    in_valid = 1'b0;
    wait_out("bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 3 == 0);
      din      = 32'h0000_2222;
      cyc(1);
      chk($sformatf("bp_hold%0d", i), {30'd0, out_valid, in_ready, sign, mag},
          {30'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0005});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("bp_rel", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    cyc(40);
    chk("bp_noqueue", 64'(out_valid | busy), 64'd0);

    // Asynchronous reset in the middle of a shift.
    send("mid", 32'hF0F0_1234);
    cyc(12);
    chk("mid_pre", {62'd0, busy, sign}, {62'd0, 1'b1, 1'b1});
    #2 rst = 1'b1;
    #1;
    chk("mid_rst", {59'd0, in_ready, out_valid, busy, sign, mag != 0},
        {59'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (out_valid) n++;
    end
    chk("mid_noout", 64'(n), 64'd0);
    convert("post", 32'hFFFF_FF00, 1'b1, 32'h0000_0100);

    // Random stream with random consumer stalls.
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      w  = $urandom;
      em = w[WIDTH-1] ? (~w + 1'b1) : w;
      send("rnd", w);
      recv($sformatf("rnd%0d", i), w[WIDTH-1], em, $urandom_range(0, 3));
      n++;
    end
    chk("rnd_count", 64'(n), 64'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
